// File: rtl/bias_bank_loader_pkg.sv
// bias_bank_loader_pkg
//   Shared definitions for the bias bank loader: loader state encoding,
//   the default bias word width and the default lane count.
package bias_bank_loader_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } load_state_t;

  localparam int BIAS_W          = 18;
  localparam int DEFAULT_N_LANES = 16;

endpackage

// File: rtl/bias_bank_loader_lane_reg.sv
// bias_lane_reg
//   One bias lane: a shadow register written from the load stream and an
//   active register that takes the shadow value on promote.
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     wr_en       write d into the shadow register
//     promote     copy shadow into active
//     d           incoming bias word
//     q           active bias word
module bias_lane_reg #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic         promote,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      q      <= '0;
    end else begin
      if (wr_en)   shadow <= d;
      if (promote) q      <= shadow;
    end
  end

endmodule

// File: rtl/bias_bank_loader.sv
// bias_bank_loader
//   Streams N_adder_tree bias words into a shadow bank, then promotes the
//   whole shadow bank into the active bank (q) on swap_req.
//   Ports:
//     clk, rst_n   clock, async active-low reset
//     in_valid/in_ready/in_data   bias word stream
//     swap_req     promote a full shadow bank
//     abort        discard the shadow load in progress
//     swap_ack     one-cycle pulse aligned with the q update
//     bank_valid   active bank holds a completed load
//     fill_count   words held in the shadow bank
//     q            active bank, lane k at q[W*(k+1)-1:W*k]
//
//   state | meaning
//   LOAD  | accepting words into the shadow bank
//   FULL  | shadow bank complete, waiting for swap_req or abort
module bias_bank_loader
  import bias_bank_loader_pkg::*;
#(
  parameter int N_adder_tree = DEFAULT_N_LANES,
  parameter int W            = BIAS_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [W-1:0]                        in_data,
  input  logic                                swap_req,
  input  logic                                abort,
  output logic                                swap_ack,
  output logic                                bank_valid,
  output logic [$clog2(N_adder_tree+1)-1:0]   fill_count,
  output logic [N_adder_tree*W-1:0]           q
);

  localparam int CW = $clog2(N_adder_tree + 1);
  localparam logic [CW-1:0] LAST = CW'(N_adder_tree - 1);

  load_state_t             state;
  logic                    accept;
  logic                    promote;
  logic [N_adder_tree-1:0] wr_en;

  assign in_ready = (state == LOAD);
  // abort suppresses both the write and the promote in its cycle
  assign accept   = in_valid && (state == LOAD) && !abort;
  assign promote  = swap_req && (state == FULL) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      fill_count <= '0;
      swap_ack   <= 1'b0;
      bank_valid <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (abort) begin
        state      <= LOAD;
        fill_count <= '0;
      end else begin
        case (state)
          LOAD: begin
            if (in_valid) begin
              fill_count <= fill_count + CW'(1);
              if (fill_count == LAST) state <= FULL;
            end
          end
          FULL: begin
            if (swap_req) begin
              state      <= LOAD;
              fill_count <= '0;
              swap_ack   <= 1'b1;
              bank_valid <= 1'b1;
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

  for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
    // the fill counter points at the next lane to be written
    assign wr_en[k] = accept && (fill_count == CW'(k));

    bias_lane_reg #(.W(W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[k]),
      .promote (promote),
      .d       (in_data),
      .q       (q[W*k +: W])
    );
  end

endmodule

// File: tb/tb_bias_bank_loader.sv
module tb_bias_bank_loader;

  localparam int N  = 16;
  localparam int W  = 18;
  localparam int CW = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           swap_req = 1'b0;
  logic           abort = 1'b0;
  logic           in_ready;
  logic           swap_ack;
  logic           bank_valid;
  logic [CW-1:0]  fill_count;
  logic [N*W-1:0] q;

  int checks = 0;
  int errors = 0;

  bias_bank_loader #(.N_adder_tree(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .swap_req   (swap_req),
    .abort      (abort),
    .swap_ack   (swap_ack),
    .bank_valid (bank_valid),
    .fill_count (fill_count),
    .q          (q)
  );

  always #5 clk = ~clk;

  // Reference: a count of words held (full means count == N), shadow and
  // active arrays, and the handshake rules applied in priority order.
  int         m_cnt = 0;
  bit         m_bv = 1'b0;
  bit         m_ack = 1'b0;
  logic [W-1:0] m_shadow [N];
  logic [W-1:0] m_active [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_bv  = 1'b0;
      m_ack = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
    end else begin
      m_ack = 1'b0;
      if (abort) begin
        m_cnt = 0;
      end else if (m_cnt == N) begin
        if (swap_req) begin
          for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
          m_bv  = 1'b1;
          m_ack = 1'b1;
          m_cnt = 0;
        end
      end else if (in_valid) begin
        m_shadow[m_cnt] = in_data;
        m_cnt++;
      end
    end
  end

  function automatic logic [N*W-1:0] model_q();
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[W*i +: W] = m_active[i];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkq(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(m_cnt < N));
    chk("fill_count", int'(fill_count), m_cnt);
    chk("swap_ack", int'(swap_ack), int'(m_ack));
    chk("bank_valid", int'(bank_valid), int'(m_bv));
    chkq("q", q, model_q());
  end

  task automatic step(input bit v, input logic [W-1:0] d, input bit s, input bit a);
    in_valid = v;
    in_data  = d;
    swap_req = s;
    abort    = a;
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input logic [W-1:0] base, input bit rnd);
    for (int k = 0; k < n; k++)
      step(1'b1, rnd ? W'($urandom) : base + W'(k), 1'b0, 1'b0);
  endtask

  logic [N*W-1:0] saved;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ready_after_reset", int'(in_ready), 1);

    // full load and swap
    load_words(N, 18'h009D0, 1'b0);
    chk("full_fill", int'(fill_count), 16);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("full_ack", int'(swap_ack), 1);
    chk("full_lane0", int'(q[17:0]), 'h009D0);
    chk("full_lane15", int'(q[287:270]), 'h009DF);
    chk("full_bank_valid", int'(bank_valid), 1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("full_ack_once", int'(swap_ack), 0);

    // backpressure in FULL
    load_words(N, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, W'($urandom), 1'b0, 1'b0);
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_fill", int'(fill_count), 16);
    end
    step(1'b1, W'($urandom), 1'b1, 1'b0);
    chk("bp_swap_ack", int'(swap_ack), 1);
    chk("bp_swap_fill", int'(fill_count), 0);
    step(1'b1, 18'h12345, 1'b0, 1'b0);
    chk("bp_first_word", int'(fill_count), 1);
    load_words(N - 1, 18'h00100, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_lane0", int'(q[17:0]), 'h12345);

    // abort mid-load with a word offered
    saved = q;
    load_words(7, '0, 1'b1);
    step(1'b1, W'($urandom), 1'b0, 1'b1);
    chk("abort_fill", int'(fill_count), 0);
    chkq("abort_q_kept", q, saved);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("abort_not_accepted", int'(fill_count), 0);
    load_words(N, 18'h2A000, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("abort_reload_lane5", int'(q[W*5 +: W]), 'h2A005);
    chk("abort_reload_lane0", int'(q[W*0 +: W]), 'h2A000);

    // swap_req and abort together in FULL
    saved = q;
    load_words(N, '0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("simul_no_ack", int'(swap_ack), 0);
    chkq("simul_q_kept", q, saved);
    chk("simul_state_load", int'(in_ready), 1);
    chk("simul_fill", int'(fill_count), 0);

    // asynchronous reset mid-load
    load_words(10, '0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chkq("rst_q", q, '0);
    chk("rst_bank_valid", int'(bank_valid), 0);
    chk("rst_fill", int'(fill_count), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready_after", int'(in_ready), 1);
    load_words(N, 18'h3B000, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("rst_reload_lane0", int'(q[17:0]), 'h3B000);

    // spurious swap in LOAD
    load_words(3, 18'h01000, 1'b0);
    saved = q;
    step(1'b0, '0, 1'b1, 1'b0);
    chk("spur_no_ack", int'(swap_ack), 0);
    chkq("spur_q_kept", q, saved);
    chk("spur_fill", int'(fill_count), 3);
    load_words(N - 3, 18'h01003, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("spur_lane3", int'(q[W*3 +: W]), 'h01003);
    chk("spur_lane15", int'(q[W*15 +: W]), 'h0100F);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, W'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);
    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
